// File: rtl/cpu_pkg.sv
// Shared definitions for the SimpleCPU front end: fetch FSM states,
// instruction opcodes and basic instruction/PC constants.
package cpu_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      START = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_STEP     = 4;

   // Opcodes carried in instruction[31:26]
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/pc_next.sv
// Next-PC calculator: sequential PC+4, or the beq target
// PC+4+(sext(offset)<<2). Purely combinational; arithmetic wraps silently.
module pc_next
   import cpu_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [15:0]         offset,
   input  logic                PCSrc,
   output logic [PC_WIDTH-1:0] next_pc
);

   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] offset_ext;
   logic [PC_WIDTH-1:0] offset_bytes;

   // Sign-extend to full PC width first so the shift keeps the sign for backward branches
   always_comb begin
      seq_pc       = pc + PC_WIDTH'(PC_STEP);
      offset_ext   = {{(PC_WIDTH-16){offset[15]}}, offset};
      offset_bytes = offset_ext << 2;
      next_pc      = PCSrc ? (seq_pc + offset_bytes) : seq_pc;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the single-cycle SimpleCPU: owns the PC, fetches one word per
// instruction via req/ack, holds it in the instruction register and applies the
// control unit's PCWre/PCSrc decision. All outputs come from registers or state.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PCWre,
   input  logic                   PCSrc,
   output logic                   imemReq,
   output logic [PC_WIDTH-1:0]    imemAddr,
   input  logic                   imemAck,
   input  logic [INSTR_WIDTH-1:0] imemData,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [5:0]             operationCode,
   output logic                   insValid,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted
);

   fetch_state_t            state_reg;
   fetch_state_t            state_next;
   logic [PC_WIDTH-1:0]     pc_reg;
   logic [PC_WIDTH-1:0]     pc_target;
   logic [INSTR_WIDTH-1:0]  instr_reg;
   logic                    halted_reg;

   pc_next #(
      .PC_WIDTH(PC_WIDTH)
   ) u_pc_next (
      .pc      (pc_reg),
      .offset  (instr_reg[15:0]),
      .PCSrc   (PCSrc),
      .next_pc (pc_target)
   );

   // State register, PC, instruction register and sticky halt flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= START;
         pc_reg     <= RESET_PC;
         instr_reg  <= '0;
         halted_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == FETCH && imemAck) begin
            instr_reg <= imemData;
         end
         if (state_reg == ISSUE) begin
            if (PCWre) begin
               pc_reg <= pc_target;
            end else begin
               halted_reg <= 1'b1;
            end
         end
      end
   end

   // Next-state logic; the control unit inputs only matter during ISSUE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         START:   state_next = FETCH;
         FETCH:   state_next = imemAck ? ISSUE : FETCH;
         ISSUE:   state_next = PCWre ? FETCH : HALT;
         HALT:    state_next = HALT;
         default: state_next = START;
      endcase
   end

   // Outputs decoded from state or taken straight from registers
   always_comb begin
      imemReq       = (state_reg == FETCH);
      insValid      = (state_reg == ISSUE);
      imemAddr      = pc_reg;
      pc            = pc_reg;
      instruction   = instr_reg;
      operationCode = instr_reg[31:26];
      halted        = halted_reg;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, hand-written
// corner sequences and a randomized run against a behavioural PC model.
module tb_instruction_fetch;

   localparam logic [31:0] RPC_A = 32'h0000_0000;
   localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCWre = 1'b1;
   logic        PCSrc = 1'b0;
   logic        imemAck = 1'b0;
   logic [31:0] imemData = '0;

   logic        a_req, b_req, a_iv, b_iv, a_hlt, b_hlt;
   logic [31:0] a_addr, b_addr, a_ins, b_ins, a_pc, b_pc;
   logic [5:0]  a_opc, b_opc;

   logic        sel = 1'b0;
   logic        req, iv, hlt;
   logic [31:0] addr, ins, pcv;
   logic [5:0]  opc;

   int checks = 0;
   int failures = 0;

   logic [31:0] mpc, minstr;
   logic        mhalt;

   always #5 clk = ~clk;

   instruction_fetch #(.PC_WIDTH(32), .RESET_PC(RPC_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .PCWre(PCWre), .PCSrc(PCSrc),
      .imemReq(a_req), .imemAddr(a_addr), .imemAck(imemAck), .imemData(imemData),
      .instruction(a_ins), .operationCode(a_opc), .insValid(a_iv), .pc(a_pc),
      .halted(a_hlt));

   instruction_fetch #(.PC_WIDTH(32), .RESET_PC(RPC_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .PCWre(PCWre), .PCSrc(PCSrc),
      .imemReq(b_req), .imemAddr(b_addr), .imemAck(imemAck), .imemData(imemData),
      .instruction(b_ins), .operationCode(b_opc), .insValid(b_iv), .pc(b_pc),
      .halted(b_hlt));

   assign req  = sel ? b_req  : a_req;
   assign addr = sel ? b_addr : a_addr;
   assign ins  = sel ? b_ins  : a_ins;
   assign opc  = sel ? b_opc  : a_opc;
   assign iv   = sel ? b_iv   : a_iv;
   assign pcv  = sel ? b_pc   : a_pc;
   assign hlt  = sel ? b_hlt  : a_hlt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reset held for n edges; returns at a negedge with the DUT in FETCH
   task automatic do_reset(input int n);
      logic [31:0] rpc;
      rpc = sel ? RPC_B : RPC_A;
      rst_n = 1'b0;
      imemAck = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("req_in_reset", {31'd0, req}, 32'd0);
      end
      chk("reset_pc", pcv, rpc);
      chk("reset_instr", ins, 32'd0);
      chk("reset_insvalid", {31'd0, iv}, 32'd0);
      chk("reset_halted", {31'd0, hlt}, 32'd0);
      rst_n = 1'b1;
      chk("req_in_start", {31'd0, req}, 32'd0);
      @(negedge clk);
      mpc = rpc;
      minstr = '0;
      mhalt = 1'b0;
      $display("reset: pc=%h", rpc);
   endtask

   // One fetch/issue transaction; model updated from the instruction rules
   task automatic do_instr(input logic [31:0] word, input int waits, input logic wre,
                           input logic src, output logic [31:0] obs_next);
      int cnt;
      longint t;
      cnt = 0;
      while (!req && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      if (!req) begin
         failures++;
         checks++;
         $display("FAIL req_timeout actual=0 required=1");
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "fetch request never arrived");
      end
      chk("fetch_addr", addr, mpc);
      chk("fetch_insvalid", {31'd0, iv}, 32'd0);
      for (int i = 0; i < waits; i++) begin
         imemAck = 1'b0;
         imemData = $urandom;
         PCWre = 1'($urandom);
         PCSrc = 1'($urandom);
         @(negedge clk);
         chk("wait_req", {31'd0, req}, 32'd1);
         chk("wait_addr", addr, mpc);
         chk("wait_instr", ins, minstr);
         chk("wait_insvalid", {31'd0, iv}, 32'd0);
      end
      imemAck = 1'b1;
      imemData = word;
      PCWre = 1'($urandom);
      PCSrc = 1'($urandom);
      @(negedge clk);
      minstr = word;
      imemAck = 1'($urandom);
      imemData = $urandom;
      chk("issue_insvalid", {31'd0, iv}, 32'd1);
      chk("issue_instr", ins, word);
      chk("issue_opcode", {26'd0, opc}, {26'd0, word[31:26]});
      chk("issue_pc", pcv, mpc);
      chk("issue_req", {31'd0, req}, 32'd0);
      PCWre = wre;
      PCSrc = src;
      @(negedge clk);
      imemAck = 1'b0;
      PCWre = 1'b1;
      PCSrc = 1'b0;
      if (!wre) begin
         mhalt = 1'b1;
      end else begin
         t = longint'(mpc) + 64'sd4;
         if (src) t = t + longint'($signed(word[15:0])) * 64'sd4;
         mpc = t[31:0];
      end
      chk("next_pc", pcv, mpc);
      chk("next_halted", {31'd0, hlt}, {31'd0, mhalt});
      chk("next_instr", ins, minstr);
      chk("next_insvalid", {31'd0, iv}, 32'd0);
      chk("next_req", {31'd0, req}, {31'd0, ~mhalt});
      if (!mhalt) chk("next_addr", addr, mpc);
      obs_next = pcv;
      $display("instr word=%h waits=%0d wre=%0b src=%0b -> pc=%h halted=%0b",
               word, waits, wre, src, pcv, hlt);
   endtask

   typedef struct {
      logic [31:0] word;
      int          waits;
      logic        wre;
      logic        src;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [31:0] obs;
      logic [31:0] w;

      tbl[0] = '{32'h0000_0000, 0, 1'b1, 1'b0, 32'h0000_0004};
      tbl[1] = '{32'h0400_0000, 1, 1'b1, 1'b0, 32'h0000_0008};
      tbl[2] = '{32'h4000_0005, 2, 1'b1, 1'b0, 32'h0000_000C};
      tbl[3] = '{32'hC000_0000, 0, 1'b1, 1'b1, 32'h0000_0010};
      tbl[4] = '{32'h4400_0000, 3, 1'b1, 1'b0, 32'h0000_0014};
      tbl[5] = '{32'hC000_0002, 0, 1'b1, 1'b1, 32'h0000_0020};
      tbl[6] = '{32'hC000_FFFE, 0, 1'b1, 1'b1, 32'h0000_001C};
      tbl[7] = '{32'hC000_0000, 1, 1'b1, 1'b1, 32'h0000_0020};
      tbl[8] = '{32'hC000_0003, 0, 1'b1, 1'b0, 32'h0000_0024};
      tbl[9] = '{32'hFC00_0000, 0, 1'b0, 1'b1, 32'h0000_0024};

      // Reset with 3 cycles low, then the directed table
      @(negedge clk);
      sel = 1'b0;
      do_reset(3);
      chk("first_req", {31'd0, req}, 32'd1);
      chk("first_addr", addr, 32'd0);
      for (int i = 0; i < 10; i++) begin
         do_instr(tbl[i].word, tbl[i].waits, tbl[i].wre, tbl[i].src, obs);
         chk($sformatf("table_pc[%0d]", i), obs, tbl[i].exp_pc);
      end

      // Halted: frozen for 20 cycles despite spurious acks and control inputs
      for (int i = 0; i < 20; i++) begin
         imemAck = 1'($urandom);
         imemData = $urandom;
         PCWre = 1'($urandom);
         PCSrc = 1'($urandom);
         @(negedge clk);
         chk("halt_req", {31'd0, req}, 32'd0);
         chk("halt_pc", pcv, 32'h0000_0024);
         chk("halt_instr", ins, 32'hFC00_0000);
         chk("halt_flag", {31'd0, hlt}, 32'd1);
         chk("halt_insvalid", {31'd0, iv}, 32'd0);
      end
      imemAck = 1'b0;
      PCWre = 1'b1;
      PCSrc = 1'b0;
      $display("halt hold: 20 cycles done");
      do_reset(1);

      // Reset while a fetch is waiting; a late ack in START must be ignored
      do_instr(32'h0000_0000, 0, 1'b1, 1'b0, obs);
      imemAck = 1'b0;
      @(negedge clk);
      chk("midfetch_req", {31'd0, req}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midfetch_req_after_reset", {31'd0, req}, 32'd0);
      rst_n = 1'b1;
      imemAck = 1'b1;
      imemData = 32'hDEAD_BEEF;
      @(negedge clk);
      imemAck = 1'b0;
      chk("midfetch_instr", ins, 32'd0);
      chk("midfetch_restart_req", {31'd0, req}, 32'd1);
      chk("midfetch_restart_addr", addr, RPC_A);
      mpc = RPC_A;
      minstr = '0;
      $display("reset mid-fetch: restart at %h", addr);
      do_instr(32'h0800_0000, 1, 1'b1, 1'b0, obs);
      chk("midfetch_next_pc", obs, 32'h0000_0004);

      // Wrap-around on the instance whose reset PC is 0xFFFFFFFC
      sel = 1'b1;
      do_reset(2);
      do_instr(32'h0000_0000, 0, 1'b1, 1'b0, obs);
      chk("wrap_seq", obs, 32'h0000_0000);
      do_instr(32'hC000_FFFB, 0, 1'b1, 1'b1, obs);
      chk("wrap_back", obs, 32'hFFFF_FFF0);
      do_instr(32'hC000_7FFF, 2, 1'b1, 1'b1, obs);
      chk("wrap_fwd", obs, 32'h0001_FFF0);

      // Randomized run against the behavioural model, ending in a halt
      sel = 1'b0;
      do_reset(2);
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         do_instr(w, int'($urandom_range(0, 3)), 1'b1, 1'($urandom), obs);
      end
      do_instr(32'hFC00_0000, 1, 1'b0, 1'b0, obs);
      @(negedge clk);
      chk("rand_halt_pc", pcv, mpc);
      chk("rand_halt_flag", {31'd0, hlt}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream fetch stage of the single-cycle SimpleCPU. It owns the program counter and fetches one 32-bit word per instruction from instruction memory using a req/ack handshake. It holds the word in an instruction register and presents `operationCode` to the control unit. It then applies the control unit's `PCWre`/`PCSrc` decision to pick the next PC: sequential, beq target, or halt.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC and instruction-memory address.
- `RESET_PC`, 0, PC value loaded by reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `PCWre`  in  1  from control unit; 0 means halt (opcode 111111).
- `PCSrc`  in  1  from control unit; 1 means take branch (beq & zero).
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  PC_WIDTH  fetch address; equals `pc`.
- `imemAck`  in  1  memory has `imemData` valid this cycle.
- `imemData`  in  32  fetched word.
- `instruction`  out  32  instruction register contents.
- `operationCode`  out  6  `instruction[31:26]`.
- `insValid`  out  1  instruction register holds the current instruction; the datapath may commit this cycle.
- `pc`  out  PC_WIDTH  address of the current instruction.
- `halted`  out  1  sticky halt indicator.

## Operation
- States: START, FETCH, ISSUE, HALT.
- **Reset** (`rst_n`=0 at an edge) sets:
  - state to START and `pc` to RESET_PC;
  - `instruction`, `insValid`, `halted` to 0.
  - `imemReq` is 0 in START.
- **START**: `imemReq`=0. Next state is FETCH unconditionally.
- **FETCH**:
  - `imemReq`=1 and `imemAddr`=`pc`; both are held stable until ack.
  - On `imemAck`=1: `instruction` <= `imemData`, next state is ISSUE.
  - Otherwise stay in FETCH.
- **ISSUE**: `insValid`=1 for exactly this one cycle. `PCWre`/`PCSrc` are sampled at the end of the cycle:
  - `PCWre`=0: `pc` is unchanged and next state is HALT.
  - `PCWre`=1, `PCSrc`=0: `pc` <= `pc`+4, next state is FETCH.
  - `PCWre`=1, `PCSrc`=1: `pc` <= `pc`+4+(sext(`instruction[15:0]`)<<2), next state is FETCH.
- **HALT**:
  - `halted`=1, `imemReq`=0, `insValid`=0.
  - `instruction` and `pc` are frozen.
  - Only reset leaves HALT.
- **Arithmetic**:
  - All PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
  - The offset is sign-extended from 16 bits to PC_WIDTH before the shift.
  - Negative offsets branch backward.
- `imemAck` outside FETCH is ignored and never modifies `instruction`.
- `PCSrc`/`PCWre` outside ISSUE are ignored.
- **Reset mid-fetch**: an outstanding request is abandoned. `imemReq` is 0 in the cycle after the reset edge, and a late ack is ignored (state is START).

## Timing
- Outputs are registered or decoded from state only. There is no combinational path from `imemAck`, `PCWre` or `PCSrc` to any output.
- **Zero-wait memory** (ack in the same cycle as req): one instruction every 2 cycles (FETCH, ISSUE).
- With N wait cycles: N+2 cycles per instruction.
- **First fetch**: `imemReq` rises in the 2nd cycle after `rst_n` rises (START, then FETCH).
- **Visibility after ack**: `instruction`/`operationCode` update one edge after the ack cycle. `insValid` is high in that following cycle.
- **PC update**: the new `pc` is visible one edge after ISSUE and is the FETCH address the same cycle.
- **Halt**: `halted` rises one edge after the ISSUE cycle in which `PCWre`=0.

## Structure
- Shared package `cpu_pkg`:
  - state enum `fetch_state_t` (START, FETCH, ISSUE, HALT);
  - opcode constants (OP_ADD=000000, OP_SUB=000001, OP_ORI=010000, OP_AND=010001, OP_OR=010010, OP_MOVE=100000, OP_SW=100110, OP_LW=100111, OP_BEQ=110000, OP_HALT=111111);
  - `INSTR_WIDTH`=32 and `PC_STEP`=4.
- One combinational sub-module `pc_next`:
  - inputs: `pc`, `instruction[15:0]`, `PCSrc`;
  - output: the next PC (sequential or branch target).
  - The FSM and all registers stay in `instruction_fetch`.

## Test plan
- **Reset and first fetch**: hold `rst_n`=0 for 3 cycles, then release, with zero-wait memory returning 0x00000000 (add) at addr 0.
  - `imemReq` is 0 through reset and START.
  - Req rises with `imemAddr`=0.
  - `insValid` pulses with `operationCode`=000000.
  - `pc` then reads 4.
- **Wait states**: ack delayed 3 cycles at `pc`=0x10.
  - `imemReq` and `imemAddr` are held stable for 4 cycles.
  - `instruction` does not change until the ack; `insValid` stays 0 meanwhile.
- **Branch**: `pc`=0x20, word 0xC000FFFE (beq, offset -2), `PCSrc`=1 in ISSUE.
  - Next `pc`=0x1C.
  - Repeat with offset 0x0003 and `PCSrc`=0: next `pc`=0x24.
- **Halt**: word 0xFC000000 with `PCWre`=0 in ISSUE.
  - `halted`=1 from the next cycle; `pc` is frozen.
  - `imemReq` stays 0 for 20 cycles despite spurious acks; reset restores `pc`=RESET_PC.
- **Wrap-around**: RESET_PC=0xFFFFFFFC, sequential instruction.
  - Next `pc`=0x00000000.
  - Branch with offset 0x7FFF from 0xFFFFFFF0: next `pc`=0x0001FFF0.
- **Reset mid-fetch**: assert `rst_n`=0 while FETCH waits, then ack one cycle after reset release.
  - The ack is ignored and `instruction` stays 0.
  - Fetch restarts at RESET_PC.
